mips_muldiv_sequencer: RTL and testbench
========================================

# mips_muldiv_sequencer

Multi-cycle sequencer for the MIPS HI/LO multiply/divide resource. It owns the HI and LO registers and runs an iterative 32-step shift-add multiplier and a restoring divider for MULT, MULTU, DIV and DIVU. It also performs the single-cycle MTHI and MTLO writes, and stalls MFHI/MFLO while a result is pending. It sits beside the main ALU and takes its issue strobe and operation code from the instruction decode/control unit.

## Interface

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; iteration count = WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  issue strobe from the control unit.
- op_code  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- op_a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- op_b  in  WIDTH  rt operand (divisor / multiplier).
- read_req  in  1  an MFHI/MFLO is in decode this cycle.
- op_ready  out  1  unit idle; an issue is accepted this cycle.
- busy  out  1  multi-cycle operation in flight.
- stall  out  1  combinational; equals read_req & busy.
- done  out  1  one-cycle pulse; HI/LO hold a new mul/div result this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation

- FSM states:
  - IDLE: op_ready=1, busy=0.
  - MUL: 32 cycles, busy=1.
  - DIV: 32 cycles, busy=1.
  - FIXUP: 1 cycle, busy=1.
- Accept condition: an issue is accepted when op_valid & op_ready and op_code is valid.
  - op_valid while op_ready=0 has no effect (no queuing).
  - Invalid codes have no effect in any state.
- MTHI/MTLO: op_a is written to hi/lo at the accepting edge. The state stays IDLE and done is not pulsed.
- MULT/DIV entry: at the accepting edge, latch |op_a| and |op_b| for signed ops (raw values for unsigned) and record the signs. Load the 5-bit counter with 0, then go to MUL or DIV.
- MUL: shift-add on a 2×WIDTH accumulator, one multiplier bit per cycle. Counter increments each cycle; after count 31 go to FIXUP.
- DIV: restoring division, one quotient bit per cycle. Remainder register is WIDTH+1 bits for the trial subtract. After count 31 go to FIXUP.
- FIXUP:
  - MULT: negate the 64-bit product (two's complement) if the sign of a differs from the sign of b.
  - DIV: negate the quotient if the signs of a and b differ; negate the remainder if a was negative.
  - Write hi/lo: multiply gives HI = upper word, LO = lower word; divide gives LO = quotient, HI = remainder.
  - Go to IDLE and set done for the next cycle.
- Divide by zero (DIV and DIVU): LO = 0xFFFFFFFF, HI = op_a as issued. No sign fixup is applied.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, with no trap.
- hi/lo are never modified during MUL/DIV. Intermediate values live in private registers only.

## Timing

- Reset: state=IDLE, hi=0, lo=0, done=0, busy=0, op_ready=1, counter=0. A reset mid-operation aborts it with no done pulse and zeroes hi/lo.
- Cycle numbering: cycle 0 is the issue cycle.
  - Cycles 1–32: MUL/DIV.
  - Cycle 33: FIXUP.
  - Cycle 34: IDLE, done=1, new hi/lo visible.
- Issue-to-result latency is 34 cycles. busy is high in cycles 1–33.
- A new issue is accepted in the done cycle (back-to-back). An MTHI/MTLO in that cycle overwrites the result at that edge.
- stall is combinational and clears in cycle 34, so MFHI/MFLO read the new value that cycle.
- MTHI/MTLO: new value is visible the cycle after issue.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001.
  - done exactly in cycle 34; busy high in cycles 1–33 only.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Immediately issue MULT 0x80000000 × 0x80000000 in the done cycle → HI=0x40000000, LO=0.
- Division results:
  - DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 / 2 → LO=3, HI=1.
  - DIV 7 / −2 → LO=0xFFFFFFFD, HI=1.
- Division edge cases:
  - DIVU 0x1234 / 0 → HI=0x1234, LO=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Stall and ignored issue:
  - Hold read_req=1 during a DIV: stall=1 in cycles 1–33 and 0 in cycle 34.
  - Pulse op_valid with MTLO 0xAAAA in cycle 5: it is ignored and LO equals the quotient afterward.
  - Then issue MTHI 0x55 from IDLE: hi=0x55 next cycle, no done.
- Reset mid-operation: assert reset in cycle 10 of a MULTU. Next cycle hi=lo=0, op_ready=1, busy=0, and done never pulses. A following MULTU 3×4 gives LO=12 at cycle 34.

Source files
------------

// File: rtl/mips_muldiv_sequencer.sv
// mips_muldiv_sequencer
//
// Owns the MIPS HI/LO registers. It runs an iterative 32-step shift-add multiplier and
// a restoring divider for MULT, MULTU, DIV and DIVU, performs single-cycle MTHI/MTLO
// writes, and stalls MFHI/MFLO while a multi-cycle result is pending.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   op_valid  issue strobe from the control unit
//   op_code   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO (110/111 ignored)
//   op_a      rs operand (multiplicand / dividend / MTHI-MTLO source)
//   op_b      rt operand (multiplier / divisor)
//   read_req  MFHI/MFLO in decode this cycle
//   op_ready  unit idle; an issue is accepted this cycle
//   busy      multi-cycle operation in flight
//   stall     read_req & busy (combinational)
//   done      one-cycle pulse when HI/LO hold a new mul/div result
//   hi, lo    HI and LO registers
module mips_muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             read_req,
  output logic             op_ready,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFixup} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // multiply accumulator {partial sum, multiplier}
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder, always < divisor
  logic [WIDTH-1:0]     quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 is_div_q, is_div_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 op_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 last_iter;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_trial;        // WIDTH+1 bits so bit WIDTH is the borrow
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign op_ready = (state_q == StIdle);
  assign busy     = ~op_ready;
  assign stall    = read_req & busy;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Codes 110/111 are not valid and never accepted.
  assign accept    = op_valid & op_ready & ~(op_code[2] & op_code[1]);
  assign op_signed = ~op_code[0];
  assign a_neg     = op_signed & op_a[WIDTH-1];
  assign b_neg     = op_signed & op_b[WIDTH-1];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  // One iteration of each datapath.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, opnd_q};
  end

  // Sign correction of the magnitude results. A zero divisor bypasses it so HI
  // returns the dividend exactly as issued.
  always_comb begin
    prod_fix = acc_q;
    quo_fix  = quo_q;
    rem_fix  = rem_q;
    if (sign_a_q ^ sign_b_q) begin
      prod_fix = -acc_q;
    end
    if (!div0_q) begin
      if (sign_a_q ^ sign_b_q) begin
        quo_fix = -quo_q;
      end
      if (sign_a_q) begin
        rem_fix = -rem_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op_code)
            OpMthi: hi_d = op_a;
            OpMtlo: lo_d = op_a;
            OpMult, OpMultu: begin
              opnd_d   = a_mag;
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              cnt_d    = '0;
              sign_a_d = a_neg;
              sign_b_d = b_neg;
              is_div_d = 1'b0;
              div0_d   = 1'b0;
              state_d  = StMul;
            end
            OpDiv, OpDivu: begin
              opnd_d   = b_mag;
              // With a zero divisor the restoring loop yields all-ones quotient and the
              // untouched dividend as remainder, so load the raw operand.
              quo_d    = (op_b == '0) ? op_a : a_mag;
              rem_d    = '0;
              cnt_d    = '0;
              sign_a_d = a_neg;
              sign_b_d = b_neg;
              is_div_d = 1'b1;
              div0_d   = (op_b == '0);
              state_d  = StDiv;
            end
            default: ;
          endcase
        end
      end

      StMul: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StFixup;
        end
      end

      StDiv: begin
        if (!rem_trial[WIDTH]) begin
          rem_d = rem_trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StFixup;
        end
      end

      StFixup: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mips_muldiv_sequencer.sv
// Self-checking bench for mips_muldiv_sequencer: an issue-side model pushes expected
// HI/LO results into a scoreboard; a negedge monitor pops them on done and checks
// busy/op_ready/stall and the architectural HI/LO every cycle.
module tb_mips_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        read_req = 1'b0;
  logic        op_ready, busy, stall, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mips_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .read_req (read_req),
    .op_ready (op_ready),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          pend = -1;      // issue cycle of the last accepted mul/div
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Result of a mul/div op as {HI, LO}, by plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, rq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin
        rq = 64'(sa * sb);
        return rq;
      end
      3'd1: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 3'd2) begin
          q  = sa / sb;
          r  = sa % sb;
          rq = 64'(q);
          rr = 64'(r);
        end else begin
          rq = ua / ub;
          rr = ua % ub;
        end
        return {rr[31:0], rq[31:0]};
      end
    endcase
  endfunction

  function automatic bit model_idle();
    return (pend < 0) || (cyc >= pend + 34);
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return 32'(-int'($urandom_range(1, 20)));
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one cycle; the model decides whether it is accepted.
  task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit          acc;
    logic [63:0] r;
    exp_t        e;
    acc      = model_idle();
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    if (acc && op <= 3'd3) begin
      r    = ref_op(op, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.t  = cyc;
      sb_q.push_back(e);
      pend = cyc;
    end
    step();
    op_valid = 1'b0;
    if (acc && op == 3'd4) m_hi = a;
    if (acc && op == 3'd5) m_lo = a;
  endtask

  // Advance until the model is idle; optionally throw ignored issues at the busy unit.
  task automatic wait_idle(input bit junk);
    for (int i = 0; i < 200; i++) begin
      if (model_idle()) break;
      if (junk) begin
        read_req = 1'($urandom_range(0, 1));
        op_valid = ($urandom_range(0, 3) == 0);
        op_code  = 3'($urandom_range(0, 7));
        op_a     = $urandom;
        op_b     = $urandom;
      end
      step();
    end
    op_valid = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle(1'b0);
    issue_op(op, a, b);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   eb;
    if (chk_en) begin
      eb = (pend >= 0) && (cyc > pend) && (cyc <= pend + 33);
      chk("busy", busy, eb);
      chk("op_ready", op_ready, !eb);
      chk("stall", stall, read_req & eb);
      if (sb_q.size() > 0 && (done || cyc >= sb_q[0].t + 34)) begin
        e = sb_q.pop_front();
        chk("done", done, 1'b1);
        chk("latency", 64'(cyc - e.t), 64'd34);
        chk("hi_result", hi, e.hi);
        chk("lo_result", lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
      end else begin
        chk("no_done", done, 1'b0);
      end
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Directed results, issued at the earliest idle cycle (back-to-back in done cycles).
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd0, 32'hFFFF_FFFD, 32'd7);
    run(3'd0, 32'h8000_0000, 32'h8000_0000);
    run(3'd2, 32'hFFFF_FFF9, 32'd2);
    run(3'd3, 32'd7, 32'd2);
    run(3'd2, 32'd7, 32'hFFFF_FFFE);
    run(3'd3, 32'h0000_1234, 32'd0);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd2, 32'hFFFF_FFF0, 32'd0);

    // Stall held through a DIV, with an MTLO that must be ignored in cycle 5.
    wait_idle(1'b0);
    read_req = 1'b1;
    issue_op(3'd2, 32'd100, 32'd7);
    repeat (4) step();
    issue_op(3'd5, 32'h0000_AAAA, 32'd0);
    wait_idle(1'b0);
    step();
    read_req = 1'b0;

    // MTHI from idle.
    issue_op(3'd4, 32'h0000_0055, 32'd0);
    step();

    // Reset in cycle 10 of a MULTU.
    issue_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_q.delete();
    pend = -1;
    m_hi = '0;
    m_lo = '0;
    issue_op(3'd1, 32'd3, 32'd4);

    // Randomized ops, including invalid codes, gaps and ignored issues while busy.
    for (int n = 0; n < 60; n++) begin
      wait_idle(1'b1);
      repeat ($urandom_range(0, 2)) step();
      read_req = 1'($urandom_range(0, 1));
      issue_op(3'($urandom_range(0, 7)), rv(), rv());
    end

    wait_idle(1'b0);
    repeat (3) step();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
